// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one outstanding request at a
// time to a variable-latency instruction memory, and holds the fetched
// instruction plus PC+4 in the IF/ID register. A one-entry skid buffer
// catches a response that arrives while the pipeline is stalled.
module if_stage #(
    parameter int                    ADDR_WIDTH    = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC      = '0,
    parameter logic [5:0]            BUBBLE_OPCODE = 6'b111111
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_valid,
    input  logic [31:0]           imem_rdata,
    output logic                  if_id_valid,
    output logic [31:0]           if_id_instr,
    output logic [ADDR_WIDTH-1:0] if_id_pc4,
    output logic [5:0]            opcode
);

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD, S_DISCARD} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc4_d;
    logic [ADDR_WIDTH-1:0] if_id_pc4_q;
    logic [31:0]           if_id_instr_q;
    logic [31:0]           skid_q;
    logic                  if_id_valid_q;
    logic                  load_en;
    logic [31:0]           load_data;
    logic                  unused_rpc_lo;

    // Redirect targets are word aligned; the low bits are dropped on purpose.
    assign unused_rpc_lo = ^redirect_pc[1:0];

    // PC arithmetic wraps naturally at 2^ADDR_WIDTH.
    assign pc4_d = pc_q + ADDR_WIDTH'(4);

    // Decide whether an instruction enters IF/ID this cycle and from where:
    // straight from memory in WAIT, or from the skid buffer in HOLD.
    always_comb begin
        load_en   = 1'b0;
        load_data = skid_q;
        if (!stall) begin
            case (state_q)
                S_WAIT: begin
                    if (imem_valid) begin
                        load_en   = 1'b1;
                        load_data = imem_rdata;
                    end
                end
                S_HOLD:  load_en = 1'b1;
                default: ;
            endcase
        end
    end

    // Fetch FSM, PC, skid buffer and IF/ID register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_PC;
            if_id_valid_q <= 1'b0;
            if_id_instr_q <= '0;
            if_id_pc4_q   <= '0;
            skid_q        <= '0;
        end else if (redirect) begin
            // Redirect beats stall. A request still in flight must be
            // drained in DISCARD; a response landing right now, or one
            // parked in the skid buffer, is simply dropped.
            pc_q          <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            if_id_valid_q <= 1'b0;
            if (state_q == S_HOLD || (state_q != S_FETCH && imem_valid))
                state_q <= S_FETCH;
            else
                state_q <= S_DISCARD;
        end else if (load_en) begin
            if_id_valid_q <= 1'b1;
            if_id_instr_q <= load_data;
            if_id_pc4_q   <= pc4_d;
            pc_q          <= pc4_d;
            state_q       <= S_FETCH;
        end else begin
            // Nothing loaded: insert a bubble unless stalled (stall holds IF/ID).
            if (!stall)
                if_id_valid_q <= 1'b0;
            case (state_q)
                S_FETCH: state_q <= S_WAIT;
                S_WAIT: begin
                    // Only reachable with stall=1 when the response arrives.
                    if (imem_valid) begin
                        skid_q  <= imem_rdata;
                        state_q <= S_HOLD;
                    end
                end
                S_DISCARD: begin
                    if (imem_valid)
                        state_q <= S_FETCH;
                end
                default: ;
            endcase
        end
    end

    // The request is suppressed while reset is asserted.
    assign imem_req    = (state_q == S_FETCH) && !rst;
    assign imem_addr   = pc_q;
    assign if_id_valid = if_id_valid_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_pc4   = if_id_pc4_q;
    assign opcode      = if_id_valid_q ? if_id_instr_q[31:26] : BUBBLE_OPCODE;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus a randomized run
// against a transaction-level model of the fetch stream.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic [5:0]  opcode;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory model knobs and single-slot pending request.
    int          mem_lat  = 1;
    bit          mem_rand = 1'b0;
    bit          m_pend   = 1'b0;
    int          m_cnt    = 0;
    logic [31:0] m_addr   = '0;

    if_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
        .if_id_pc4(if_id_pc4), .opcode(opcode)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h8C22_0004;
        if (a == 32'h4) return 32'h0043_2020;
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    // Instruction memory: a request seen in cycle N is answered in cycle
    // N+lat. It knows nothing about reset, so stale replies are possible.
    always @(negedge clk) begin
        imem_valid = 1'b0;
        if (m_pend) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                imem_valid = 1'b1;
                imem_rdata = mem_word(m_addr);
                m_pend     = 1'b0;
            end
        end
        if (imem_req) begin
            m_pend = 1'b1;
            m_cnt  = mem_rand ? int'($urandom_range(1, 4)) : mem_lat;
            m_addr = imem_addr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Long enough for any outstanding memory reply to drain.
    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        repeat (6) tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic wait_req(input int bound, output bit ok);
        int i = 0;
        while (!imem_req && i < bound) begin tick(); i++; end
        ok = imem_req;
    endtask

    task automatic wait_load(input int bound, output bit ok);
        int i = 0;
        while (!if_id_valid && i < bound) begin tick(); i++; end
        ok = if_id_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        tick();
        n_checks++;
        if (imem_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_req: got %b want 0", imem_req);
        end
        repeat (5) tick();
        n_checks++;
        if ({if_id_valid, if_id_instr, if_id_pc4} !== 65'h0) begin
            n_fail++; $display("FAIL reset_ifid: got %b/%h/%h want 0/0/0", if_id_valid, if_id_instr, if_id_pc4);
        end
        n_checks++;
        if (opcode !== 6'b111111) begin
            n_fail++; $display("FAIL reset_opcode: got %b want 111111", opcode);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            n_fail++; $display("FAIL reset_first_req: got %b/%h want 1/0", imem_req, imem_addr);
        end
    endtask

    task automatic test_basic();
        mem_lat = 1; mem_rand = 1'b0;
        do_reset();
        n_checks++;
        if ({imem_req, imem_addr, opcode} !== {1'b1, 32'h0, 6'b111111}) begin
            n_fail++; $display("FAIL basic_req0: got %b/%h/%b want 1/0/111111", imem_req, imem_addr, opcode);
        end
        tick();
        n_checks++;
        if (imem_req !== 1'b0) begin
            n_fail++; $display("FAIL basic_wait_req: got %b want 0", imem_req);
        end
        tick();
        n_checks++;
        if ({if_id_valid, if_id_instr, if_id_pc4, opcode} !== {1'b1, 32'h8C22_0004, 32'h4, 6'b100011}) begin
            n_fail++; $display("FAIL basic_load0: got %b/%h/%h/%b want 1/8c220004/4/100011", if_id_valid, if_id_instr, if_id_pc4, opcode);
        end
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h4}) begin
            n_fail++; $display("FAIL basic_req4: got %b/%h want 1/4", imem_req, imem_addr);
        end
        tick(); tick();
        n_checks++;
        if ({if_id_valid, if_id_instr, if_id_pc4, opcode} !== {1'b1, 32'h0043_2020, 32'h8, 6'b000000}) begin
            n_fail++; $display("FAIL basic_load4: got %b/%h/%h/%b want 1/00432020/8/000000", if_id_valid, if_id_instr, if_id_pc4, opcode);
        end
    endtask

    task automatic test_stall();
        bit ok;
        logic [64:0] snap;
        mem_lat = 3; mem_rand = 1'b0;
        do_reset();
        wait_load(10, ok);
        n_checks++;
        if (!ok || if_id_instr !== mem_word(32'h0)) begin
            n_fail++; $display("FAIL stall_first_load: got %b/%h want 1/%h", ok, if_id_instr, mem_word(32'h0));
        end
        tick();
        stall = 1'b1;
        snap = {if_id_valid, if_id_instr, if_id_pc4};
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if ({if_id_valid, if_id_instr, if_id_pc4} !== snap) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got %h want %h", i, {if_id_valid, if_id_instr, if_id_pc4}, snap);
            end
            n_checks++;
            if (imem_req !== 1'b0) begin
                n_fail++; $display("FAIL stall_no_req[%0d]: got %b want 0", i, imem_req);
            end
        end
        stall = 1'b0;
        tick();
        n_checks++;
        if ({if_id_valid, if_id_instr, if_id_pc4} !== {1'b1, mem_word(32'h4), 32'h8}) begin
            n_fail++; $display("FAIL stall_release_load: got %b/%h/%h want 1/%h/8", if_id_valid, if_id_instr, if_id_pc4, mem_word(32'h4));
        end
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h8}) begin
            n_fail++; $display("FAIL stall_next_req: got %b/%h want 1/8", imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_wait();
        bit ok;
        int i;
        mem_lat = 3; mem_rand = 1'b0;
        do_reset();
        tick();
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        redirect = 1'b0; redirect_pc = '0;
        i = 0;
        while (!imem_req && i < 10) begin
            n_checks++;
            if ({if_id_valid, opcode} !== {1'b0, 6'b111111}) begin
                n_fail++; $display("FAIL redir_bubble: got %b/%b want 0/111111", if_id_valid, opcode);
            end
            tick(); i++;
        end
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h100}) begin
            n_fail++; $display("FAIL redir_target: got %b/%h want 1/100", imem_req, imem_addr);
        end
        wait_load(10, ok);
        n_checks++;
        if ({ok, if_id_instr, if_id_pc4} !== {1'b1, mem_word(32'h100), 32'h104}) begin
            n_fail++; $display("FAIL redir_load: got %b/%h/%h want 1/%h/104", ok, if_id_instr, if_id_pc4, mem_word(32'h100));
        end
    endtask

    task automatic test_redirect_same();
        bit ok;
        mem_lat = 2; mem_rand = 1'b0;
        do_reset();
        tick(); tick();
        redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0; stall = 1'b0; redirect_pc = '0;
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h200}) begin
            n_fail++; $display("FAIL same_cycle_fetch: got %b/%h want 1/200", imem_req, imem_addr);
        end
        n_checks++;
        if ({if_id_valid, if_id_instr} !== {1'b0, 32'h0}) begin
            n_fail++; $display("FAIL same_cycle_drop: got %b/%h want 0/0", if_id_valid, if_id_instr);
        end
        wait_load(10, ok);
        n_checks++;
        if ({ok, if_id_instr, if_id_pc4} !== {1'b1, mem_word(32'h200), 32'h204}) begin
            n_fail++; $display("FAIL same_cycle_load: got %b/%h/%h want 1/%h/204", ok, if_id_instr, if_id_pc4, mem_word(32'h200));
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        mem_lat = 1; mem_rand = 1'b0;
        do_reset();
        wait_load(10, ok);
        mem_lat = 2;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if ({if_id_valid, if_id_instr, if_id_pc4} !== 65'h0) begin
            n_fail++; $display("FAIL midrst_ifid: got %b/%h/%h want 0/0/0", if_id_valid, if_id_instr, if_id_pc4);
        end
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            n_fail++; $display("FAIL midrst_req: got %b/%h want 1/0", imem_req, imem_addr);
        end
        wait_load(10, ok);
        n_checks++;
        if ({ok, if_id_instr, if_id_pc4} !== {1'b1, mem_word(32'h0), 32'h4}) begin
            n_fail++; $display("FAIL midrst_load: got %b/%h/%h want 1/%h/4", ok, if_id_instr, if_id_pc4, mem_word(32'h0));
        end
    endtask

    task automatic test_wrap();
        bit ok;
        mem_lat = 1; mem_rand = 1'b0;
        do_reset();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect = 1'b0; redirect_pc = '0;
        wait_req(6, ok);
        n_checks++;
        if ({ok, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
            n_fail++; $display("FAIL wrap_req: got %b/%h want 1/fffffffc", ok, imem_addr);
        end
        tick();
        wait_load(6, ok);
        n_checks++;
        if ({ok, if_id_instr, if_id_pc4} !== {1'b1, mem_word(32'hFFFF_FFFC), 32'h0}) begin
            n_fail++; $display("FAIL wrap_load: got %b/%h/%h want 1/%h/0", ok, if_id_instr, if_id_pc4, mem_word(32'hFFFF_FFFC));
        end
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            n_fail++; $display("FAIL wrap_next_req: got %b/%h want 1/0", imem_req, imem_addr);
        end
    endtask

    // Model: fetch addresses form a sequential stream restarted by each
    // redirect; every IF/ID load must be the oldest surviving fetch, in order.
    task automatic test_random();
        logic [31:0] q[$];
        logic [31:0] exp_fetch;
        logic [64:0] pre;
        logic [31:0] a;
        int          loads = 0;
        mem_rand = 1'b1;
        do_reset();
        exp_fetch = 32'h0;
        for (int i = 0; i < 3000; i++) begin
            stall       = ($urandom_range(0, 3) == 0);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = $urandom;
            @(negedge clk);
            if (imem_req) begin
                n_checks++;
                if (imem_addr !== exp_fetch) begin
                    n_fail++; $display("FAIL rand_addr @%0d: got %h want %h", i, imem_addr, exp_fetch);
                end
            end
            if (redirect) begin
                q.delete();
                exp_fetch = {redirect_pc[31:2], 2'b00};
            end else if (imem_req) begin
                q.push_back(exp_fetch);
                exp_fetch = exp_fetch + 32'h4;
            end
            pre = {if_id_valid, if_id_instr, if_id_pc4};
            @(posedge clk);
            #1;
            if (redirect) begin
                n_checks++;
                if (if_id_valid !== 1'b0) begin
                    n_fail++; $display("FAIL rand_redir_bubble @%0d: got %b want 0", i, if_id_valid);
                end
            end else if (stall) begin
                n_checks++;
                if ({if_id_valid, if_id_instr, if_id_pc4} !== pre) begin
                    n_fail++; $display("FAIL rand_stall_hold @%0d: got %h want %h", i, {if_id_valid, if_id_instr, if_id_pc4}, pre);
                end
            end else if (if_id_valid === 1'b1) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL rand_load @%0d: got unexpected %h want no load", i, if_id_instr);
                end else begin
                    a = q.pop_front();
                    loads++;
                    if ({if_id_instr, if_id_pc4} !== {mem_word(a), a + 32'h4}) begin
                        n_fail++; $display("FAIL rand_load @%0d: got %h/%h want %h/%h", i, if_id_instr, if_id_pc4, mem_word(a), a + 32'h4);
                    end
                end
            end
        end
        stall = 1'b0; redirect = 1'b0;
        n_checks++;
        if (loads < 100) begin
            n_fail++; $display("FAIL rand_progress: got %0d loads want >= 100", loads);
        end
        mem_rand = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_redirect_wait();
        test_redirect_same();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
